mem_seg_display: RTL and testbench
==================================

# mem_seg_display

Scanning driver for an 8-digit, common-anode seven-segment display that shows the eight debug bytes exported by the data memory (bytes at addresses 0..7). It sits directly downstream of the data memory and consumes its `d0`..`d7` taps. Bytes are snapshotted once per display frame so digits never tear, and they are shown as two pages of one 32-bit little-endian word each. Brightness is PWM-controlled and leading zeros can be blanked.

## Interface
Parameters:
- `SCAN_DIV`, default 50000: clock cycles per digit slot; legal range 2..2^20; counter width is $clog2(SCAN_DIV).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `d0`..`d7`  in  8 each  memory bytes 0..7 from the data memory.
- `page`  in  1  0 shows word {d3,d2,d1,d0}; 1 shows word {d7,d6,d5,d4}.
- `freeze`  in  1  1 holds the current snapshot; frame captures are skipped.
- `lzb`  in  1  1 enables leading-zero blanking.
- `level`  in  3  brightness; 0 is dimmest and 7 is always on.
- `an`  out  8  digit enables, active-low; `an[0]` is the rightmost digit.
- `seg`  out  7  segments a..g on bits 0..6, active-low.
- `dp`  out  1  decimal point, active-low.
- `frame`  out  1  one-cycle pulse on each frame boundary.

## Operation
- Internal state:
  - `div` counter, 0..SCAN_DIV-1.
  - Digit index `idx`, 3 bits.
  - 3-bit free-running PWM phase `ph`, incremented every cycle.
  - 32-bit shadow word `sh`.
  - Latched page `pg`.
  - `prime` flag.
- Tick: asserted when `div == SCAN_DIV-1`. On a tick, `div` returns to 0 and `idx` increments modulo 8.
- Frame boundary is a tick with `idx == 7`, or the first cycle with `prime` set. At a frame boundary:
  - `pg` is loaded from `page`.
  - If `freeze` is 0, `sh` is loaded with the word selected by `page`. If `prime` is set, `sh` is loaded regardless of `freeze`.
  - `prime` is cleared.
  - `frame` pulses for one cycle.
- Digit nibble: digit `k` shows `sh[4k+3:4k]`. Digit 0 is the low nibble of the lower-address byte.
- Font is standard hex, shown as glyphs 0-9, A, b, C, d, E, F.
  - `seg` active-low, g..a order: 0 = 1000000, 1 = 1111001, 8 = 0000000, A = 0001000, F = 0001110.
- Leading-zero blanking: with `lzb` = 1, digit `k` for k ≥ 1 is blank when nibbles k..7 of `sh` are all zero. Digit 0 is never blanked.
- PWM: a digit is lit only when `ph <= level`. Otherwise `an` is 8'hFF.
- Decimal point: `dp` is 0 only on digit 7 while `pg` = 1.
- Blanked or unlit: `an` = 8'hFF, `seg` = 7'h7F, `dp` = 1.
- Inputs `page`, `freeze` and `lzb` are sampled only where stated. `lzb` and `level` are used combinationally before the output register.

## Timing
- Reset values:
  - `an` = 8'hFF, `seg` = 7'h7F, `dp` = 1, `frame` = 0.
  - `div` = 0, `idx` = 0, `ph` = 0, `sh` = 0, `pg` = 0, `prime` = 1.
- All outputs are registered. `an`/`seg`/`dp` reflect the `idx`, `ph` and `sh` values present one cycle earlier.
- The first capture happens on the first rising edge after reset release. The capture is visible on the outputs one edge later.
- Frame period is 8·SCAN_DIV cycles. Each digit occupies SCAN_DIV consecutive cycles.
- Changes on `d0`..`d7` mid-frame do not affect the display until the next frame boundary. Writing a byte into memory shows up within at most 8·SCAN_DIV+2 cycles.
- `freeze` asserted at a boundary skips that capture, but `pg` still updates. A page change while frozen shows the old `sh` with the new `dp`.
- Reset mid-frame: all outputs go to their reset values immediately (asynchronously). `prime` forces a fresh capture after release.
- With `level` = 7, exactly one `an` bit is low every cycle. Counting the one-cycle output lag, the lit digit is always a one-hot decode of `idx`.

## Test plan
- Reset and prime (SCAN_DIV = 4, `d0`..`d3` = 0x78, 0x56, 0x34, 0x12, `page` = 0, `level` = 7) -> outputs are FF/7F/1 during reset. Starting 2 cycles after release, digits 0..7 show 8,7,6,5,4,3,2,1. `an` steps FE, FD, ... 7F every 4 cycles.
- Tear-free update: change `d0` to 0xAB mid-frame -> the current frame keeps showing 8,7. The frame after the `frame` pulse shows B,A (`seg` 0000011, 0001000).
- Page and freeze: set `page` = 1 with `d4`..`d7` = 0xEF, 0xBE, 0xAD, 0xDE -> the next frame shows DEADBEEF with `dp` = 0 only on digit 7. Assert `freeze`, change `d4` -> the display is unchanged across 3 frames.
- Leading-zero blanking: `sh` = 0x0000_00A0, `lzb` = 1 -> digits 7..2 are blank and digits 1 and 0 show A and 0. With `sh` = 0 -> only digit 0 is lit, showing 0.
- PWM: `level` = 2 -> over any 8 consecutive cycles the digit is lit for exactly 3. `level` = 0 -> lit for 1 of 8.
- Async reset mid-frame at idx = 5 -> `an` = FF within the same cycle. After release, a capture occurs even if `freeze` = 1.

Source files
------------

// File: rtl/mem_seg_display.sv
`default_nettype none
// ============================================================================
// Module   : mem_seg_display
// Brief    : 8-digit common-anode seven-segment scanner for data-memory bytes
//            0..7, with per-frame snapshot, paging, PWM dimming and
//            leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module mem_seg_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] d0,
    input  logic [7:0] d1,
    input  logic [7:0] d2,
    input  logic [7:0] d3,
    input  logic [7:0] d4,
    input  logic [7:0] d5,
    input  logic [7:0] d6,
    input  logic [7:0] d7,
    input  logic       page,
    input  logic       freeze,
    input  logic       lzb,
    input  logic [2:0] level,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame
);

    localparam int                 c_DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);
    localparam logic [2:0]         c_IDX_LAST = 3'd7;

    logic [c_DIV_W-1:0] r_div;
    logic [2:0]         r_idx;
    logic [2:0]         r_ph;
    logic [31:0]        r_sh;
    logic               r_pg;
    logic               r_prime;

    logic               w_tick;
    logic               w_boundary;
    logic [31:0]        w_word;
    logic [31:0]        w_upper;
    logic [3:0]         w_nib;
    logic               w_blank;
    logic               w_lit;
    logic [7:0]         w_an;
    logic [6:0]         w_seg;
    logic               w_dp;

    // Active-low hex glyphs, bit order g..a.
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] s;
        s = 7'h7F;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign w_tick     = (r_div == c_DIV_LAST);
    assign w_boundary = (w_tick && (r_idx == c_IDX_LAST)) || r_prime;
    assign w_word     = page ? {d7, d6, d5, d4} : {d3, d2, d1, d0};

    // Nibbles idx..7 shifted down; zero means this digit and all above are zero.
    assign w_upper = r_sh >> {r_idx, 2'b00};
    assign w_nib   = w_upper[3:0];
    assign w_blank = lzb && (r_idx != 3'd0) && (w_upper == 32'd0);
    assign w_lit   = (r_ph <= level) && !w_blank;

    always_comb begin
        w_an  = 8'hFF;
        w_seg = 7'h7F;
        w_dp  = 1'b1;
        if (w_lit) begin
            w_an  = ~(8'h01 << r_idx);
            w_seg = glyph(w_nib);
            w_dp  = !((r_idx == c_IDX_LAST) && r_pg);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div   <= '0;
            r_idx   <= 3'd0;
            r_ph    <= 3'd0;
            r_sh    <= 32'd0;
            r_pg    <= 1'b0;
            r_prime <= 1'b1;
        end else begin
            r_ph <= r_ph + 3'd1;
            if (w_tick) begin
                r_div <= '0;
                r_idx <= r_idx + 3'd1;
            end else begin
                r_div <= r_div + c_DIV_ONE;
            end
            if (w_boundary) begin
                r_pg    <= page;
                r_prime <= 1'b0;
                // The very first frame after reset always captures so the
                // display never starts from a stale, frozen snapshot.
                if (!freeze || r_prime) begin
                    r_sh <= w_word;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an    <= 8'hFF;
            seg   <= 7'h7F;
            dp    <= 1'b1;
            frame <= 1'b0;
        end else begin
            an    <= w_an;
            seg   <= w_seg;
            dp    <= w_dp;
            frame <= w_boundary;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_seg_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_seg_display
// Brief    : Scoreboard bench for mem_seg_display against a cycle-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_seg_display;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] dm [8];
    logic       page = 1'b0;
    logic       freeze = 1'b0;
    logic       lzb = 1'b0;
    logic [2:0] level = 3'd7;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       frame;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Active-high gfedcba patterns for hex 0..F.
    logic [6:0] font_hi [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    mem_seg_display #(.SCAN_DIV(S)) dut (
        .clk(clk), .rst(rst),
        .d0(dm[0]), .d1(dm[1]), .d2(dm[2]), .d3(dm[3]),
        .d4(dm[4]), .d5(dm[5]), .d6(dm[6]), .d7(dm[7]),
        .page(page), .freeze(freeze), .lzb(lzb), .level(level),
        .an(an), .seg(seg), .dp(dp), .frame(frame)
    );

    always #5 clk = ~clk;

    // Reference model: edges since release determine digit slot and PWM phase.
    initial begin
        int          e;
        int          m;
        int          di;
        int          dph;
        logic [31:0] snap;
        logic [31:0] up;
        logic        pgm;
        exp_t        x;
        e = 0; snap = 32'd0; pgm = 1'b0;
        forever begin
            @(posedge clk);
            x = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, frame: 1'b0};
            if (rst) begin
                e = 0; snap = 32'd0; pgm = 1'b0;
            end else begin
                e++;
                m   = e - 1;
                di  = (m / S) % 8;
                dph = m % 8;
                up  = snap >> (4 * di);
                if ((dph <= int'(level)) && !(lzb && di != 0 && up == 32'd0)) begin
                    x.an  = ~(8'h01 << di);
                    x.seg = ~font_hi[up[3:0]];
                    x.dp  = !(di == 7 && pgm);
                end
                x.frame = (e == 1) || (e % (8 * S) == 0);
                if (x.frame) begin
                    pgm = page;
                    if (!freeze || e == 1)
                        snap = page ? {dm[7], dm[6], dm[5], dm[4]} : {dm[3], dm[2], dm[1], dm[0]};
                end
            end
            q.push_back(x);
        end
    end

    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                checks++;
                if ({an, seg, dp, frame} !== x) begin
                    errors++;
                    $display("FAIL outputs @%0t: got an=%h seg=%b dp=%b frame=%b, expected an=%h seg=%b dp=%b frame=%b",
                             $time, an, seg, dp, frame, x.an, x.seg, x.dp, x.frame);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pwm_check(input logic [2:0] lv, input int want);
        int lit;
        level = lv;
        cyc(8 * S + 3);
        lit = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (an != 8'hFF) lit++;
        end
        checks++;
        if (lit != want) begin
            errors++;
            $display("FAIL pwm level=%0d: lit %0d of 8, expected %0d", lv, lit, want);
        end
    endtask

    initial begin
        int  waited;
        bit  seen;
        for (int i = 0; i < 8; i++) dm[i] = 8'h00;
        dm[0] = 8'h78; dm[1] = 8'h56; dm[2] = 8'h34; dm[3] = 8'h12;
        cyc(3);
        rst = 1'b0;
        cyc(2 * 8 * S);

        // Mid-frame change must not tear the current frame.
        cyc(10);
        dm[0] = 8'hAB;
        cyc(2 * 8 * S);

        page = 1'b1;
        dm[4] = 8'hEF; dm[5] = 8'hBE; dm[6] = 8'hAD; dm[7] = 8'hDE;
        cyc(8 * S + 4);
        freeze = 1'b1;
        dm[4] = 8'h11;
        cyc(3 * 8 * S);

        freeze = 1'b0; page = 1'b0; lzb = 1'b1;
        dm[0] = 8'hA0; dm[1] = 8'h00; dm[2] = 8'h00; dm[3] = 8'h00;
        cyc(2 * 8 * S);
        dm[0] = 8'h00;
        cyc(2 * 8 * S);

        lzb = 1'b0;
        dm[0] = 8'h21; dm[1] = 8'h43;
        pwm_check(3'd2, 3);
        pwm_check(3'd0, 1);

        repeat (40) begin
            for (int i = 0; i < 8; i++) dm[i] = 8'($urandom);
            page   = 1'($urandom);
            freeze = ($urandom_range(0, 3) == 0);
            lzb    = 1'($urandom);
            level  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) dm[7] = 8'h00;
            cyc($urandom_range(1, 12) * S);
        end

        // Async reset in the middle of digit slot 5, with freeze held.
        level = 3'd7; lzb = 1'b0; freeze = 1'b1; page = 1'b0;
        seen = 1'b0; waited = 0;
        while (!seen && waited < 8 * S + 2) begin
            @(negedge clk);
            waited++;
            if (frame) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL frame_wait: no frame pulse within %0d cycles", 8 * S + 2);
        end
        cyc(5 * S + 1);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (an != 8'hFF) begin
            errors++;
            $display("FAIL async_reset: an=%h, expected ff", an);
        end
        cyc(2);
        dm[0] = 8'h9C; dm[1] = 8'h5D; dm[2] = 8'hE3; dm[3] = 8'h7F;
        rst = 1'b0;
        cyc(2 * 8 * S);

        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
